// File: rtl/symhist_pkg.sv
// Shared types and encodings for the symbol_histogram block.
package symhist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCount,
        StSearch,
        StDump
    } state_e;

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_DUMP  = 2'b10;

    // Index width able to hold every value 0..depth (table size n included).
    function automatic int unsigned idx_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/symbol_histogram_if.sv
// Symbol input stream and dump output stream of symbol_histogram, both valid/ready.
interface symbol_histogram_if #(
    parameter int unsigned SYM_W = 8,
    parameter int unsigned CNT_W = 16
);
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym_in;
    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_sym;
    logic [CNT_W-1:0] out_count;
    logic             out_last;

    modport master (
        output sym_valid, sym_in, out_ready,
        input  sym_ready, out_valid, out_sym, out_count, out_last
    );

    modport slave (
        input  sym_valid, sym_in, out_ready,
        output sym_ready, out_valid, out_sym, out_count, out_last
    );
endinterface

// File: rtl/symhist_lookup.sv
// Sequential table search: compares one entry per cycle while active_i is high.
module symhist_lookup #(
    parameter int unsigned SYM_W    = 8,
    parameter int unsigned MAX_SYMS = 32,
    parameter int unsigned NW       = 6
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               active_i,
    input  logic [SYM_W-1:0]                   sym_i,
    input  logic [NW-1:0]                      n_i,
    input  logic [MAX_SYMS-1:0][SYM_W-1:0]     tbl_i,
    output logic                               hit_o,
    output logic                               miss_done_o,
    output logic [NW-1:0]                      idx_o
);
    logic [NW-1:0]    idx_q, idx_d;
    logic [SYM_W-1:0] cur_sym;
    logic             in_range, last_entry;

    always_comb begin
        cur_sym = '0;
        for (int k = 0; k < MAX_SYMS; k++) begin
            if (NW'(k) == idx_q) cur_sym = tbl_i[k];
        end
        in_range    = idx_q < n_i;
        // Also true for an empty table, so a miss resolves in the first cycle.
        last_entry  = (idx_q + NW'(1)) >= n_i;
        hit_o       = active_i && in_range && (cur_sym == sym_i);
        miss_done_o = active_i && !hit_o && last_entry;
        if (!active_i)                     idx_d = '0;
        else if (!hit_o && !last_entry)    idx_d = idx_q + NW'(1);
        else                               idx_d = idx_q;
    end

    assign idx_o = idx_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) idx_q <= '0;
        else          idx_q <= idx_d;
    end
endmodule

// File: rtl/symbol_histogram.sv
// Programmable-alphabet symbol counter with saturating counts and a (symbol, count) dump.
// Optional SYMHIST_CLEAR_ON_READ_EN: counts and miss are zeroed as their dump beat is taken.
module symbol_histogram
    import symhist_pkg::*;
#(
    parameter int unsigned      SYM_W    = 8,
    parameter int unsigned      MAX_SYMS = 32,
    parameter int unsigned      CNT_W    = 16,
    parameter logic [SYM_W-1:0] TERM     = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          mode,
    symbol_histogram_if.slave   bus,
    output logic                busy,
    output logic                load_ovf
);
    localparam int unsigned NW = idx_width(MAX_SYMS);

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [CNT_W-1:0] cnt_t;

    state_e                         state_q, state_d;
    logic [NW-1:0]                  n_q, n_d, j_q, j_d;
    logic [MAX_SYMS-1:0][SYM_W-1:0] tbl_q, tbl_d;
    logic [MAX_SYMS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    cnt_t                           miss_q, miss_d, out_count_q, out_count_d;
    sym_t                           sym_q, sym_d, out_sym_q, out_sym_d;
    logic ovf_q, ovf_d, busy_q, busy_d, sym_ready_q, sym_ready_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;

    logic          hit, miss_done, sym_accept, out_accept, beat_last;
    logic [NW-1:0] hit_idx, beat_idx;
    sym_t          beat_sym;
    cnt_t          beat_cnt;

    function automatic cnt_t sat_inc(cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    symhist_lookup #(
        .SYM_W    (SYM_W),
        .MAX_SYMS (MAX_SYMS),
        .NW       (NW)
    ) u_lookup (
        .clock       (clock),
        .reset_n     (reset_n),
        .active_i    (state_q == StSearch),
        .sym_i       (sym_q),
        .n_i         (n_q),
        .tbl_i       (tbl_q),
        .hit_o       (hit),
        .miss_done_o (miss_done),
        .idx_o       (hit_idx)
    );

    assign sym_accept = bus.sym_valid && sym_ready_q;
    assign out_accept = out_valid_q && bus.out_ready;

    // Beat to present next: index 0 when starting a dump, j+1 after an accepted beat.
    always_comb begin
        beat_idx  = (state_q == StDump) ? j_q + NW'(1) : '0;
        beat_sym  = TERM;
        beat_cnt  = miss_q;
        beat_last = 1'b1;
        if (beat_idx < n_q) begin
            beat_last = 1'b0;
            for (int k = 0; k < MAX_SYMS; k++) begin
                if (NW'(k) == beat_idx) begin
                    beat_sym = tbl_q[k];
                    beat_cnt = cnt_q[k];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        j_d         = j_q;
        tbl_d       = tbl_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        sym_d       = sym_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        sym_ready_d = sym_ready_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (mode)
                        MODE_LOAD: begin
                            state_d     = StLoad;
                            n_d         = '0;
                            cnt_d       = '0;
                            miss_d      = '0;
                            ovf_d       = 1'b0;
                            busy_d      = 1'b1;
                            sym_ready_d = 1'b1;
                        end
                        MODE_COUNT: begin
                            state_d     = StCount;
                            busy_d      = 1'b1;
                            sym_ready_d = 1'b1;
                        end
                        MODE_DUMP: begin
                            state_d     = StDump;
                            j_d         = '0;
                            busy_d      = 1'b1;
                            out_valid_d = 1'b1;
                            out_sym_d   = beat_sym;
                            out_count_d = beat_cnt;
                            out_last_d  = beat_last;
                        end
                        default: ;
                    endcase
                end
            end
            StLoad: begin
                if (sym_accept) begin
                    if (bus.sym_in == TERM) begin
                        state_d     = StIdle;
                        busy_d      = 1'b0;
                        sym_ready_d = 1'b0;
                    end else if (n_q < NW'(MAX_SYMS)) begin
                        for (int k = 0; k < MAX_SYMS; k++) begin
                            if (NW'(k) == n_q) tbl_d[k] = bus.sym_in;
                        end
                        n_d = n_q + NW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StCount: begin
                if (sym_accept) begin
                    sym_ready_d = 1'b0;
                    if (bus.sym_in == TERM) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        sym_d   = bus.sym_in;
                        state_d = StSearch;
                    end
                end
            end
            StSearch: begin
                if (hit || miss_done) begin
                    state_d     = StCount;
                    sym_ready_d = 1'b1;
                end
                if (hit) begin
                    for (int k = 0; k < MAX_SYMS; k++) begin
                        if (NW'(k) == hit_idx) cnt_d[k] = sat_inc(cnt_q[k]);
                    end
                end else if (miss_done) begin
                    miss_d = sat_inc(miss_q);
                end
            end
            StDump: begin
                if (out_accept) begin
                    if (out_last_q) begin
                        state_d     = StIdle;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b0;
                        out_sym_d   = '0;
                        out_count_d = '0;
                        out_last_d  = 1'b0;
`ifdef SYMHIST_CLEAR_ON_READ_EN
                        miss_d      = '0;
`endif
                    end else begin
`ifdef SYMHIST_CLEAR_ON_READ_EN
                        for (int k = 0; k < MAX_SYMS; k++) begin
                            if (NW'(k) == j_q) cnt_d[k] = '0;
                        end
`endif
                        j_d         = j_q + NW'(1);
                        out_sym_d   = beat_sym;
                        out_count_d = beat_cnt;
                        out_last_d  = beat_last;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            n_q         <= '0;
            j_q         <= '0;
            tbl_q       <= '0;
            cnt_q       <= '0;
            miss_q      <= '0;
            sym_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            sym_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            j_q         <= j_d;
            tbl_q       <= tbl_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            sym_q       <= sym_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            sym_ready_q <= sym_ready_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.sym_ready = sym_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_count = out_count_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign load_ovf      = ovf_q;
endmodule

// File: tb/tb_symbol_histogram.sv
// Self-checking bench for symbol_histogram (small table, 2-bit counters to reach overflow/saturation).
module tb_symbol_histogram;
    import symhist_pkg::*;

    localparam int unsigned SYM_W    = 8;
    localparam int unsigned MAX_SYMS = 4;
    localparam int unsigned CNT_W    = 2;
    localparam logic [7:0]  TERM     = 8'h00;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       busy, load_ovf;

    symbol_histogram_if #(.SYM_W(SYM_W), .CNT_W(CNT_W)) bus ();

    symbol_histogram #(
        .SYM_W    (SYM_W),
        .MAX_SYMS (MAX_SYMS),
        .CNT_W    (CNT_W),
        .TERM     (TERM)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .bus      (bus.slave),
        .busy     (busy),
        .load_ovf (load_ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          na;
        logic [31:0] alpha;
        int          nt;
        logic [47:0] text;
        logic [7:0]  cnt;
        logic [1:0]  miss;
    } vec_t;

    vec_t        vecs[6];
    int          n_total = 0;
    int          n_pass = 0;
    logic [10:0] exp_q[$];

    function automatic logic [10:0] beat(input logic last, input logic [7:0] s,
                                         input logic [1:0] c);
        return {last, s, c};
    endfunction

    function automatic logic [14:0] outs();
        return {bus.sym_ready, bus.out_valid, bus.out_sym, bus.out_count, bus.out_last,
                busy, load_ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_sym(input logic [7:0] s);
        int g = 0;
        bus.sym_valid = 1'b1;
        bus.sym_in    = s;
        while (!bus.sym_ready && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) check("sym_ready timeout", 32'd0, 32'd1);
        tick();
        bus.sym_valid = 1'b0;
    endtask

    // Cycles from acceptance until sym_ready comes back.
    task automatic send_measure(input string name, input logic [7:0] s, input int exp_lat);
        int lat = 0;
        send_sym(s);
        while (!bus.sym_ready && lat < 100) begin
            tick();
            lat++;
        end
        check(name, lat, exp_lat);
    endtask

    task automatic dump_check(input string name, input int stall_at);
        int   b = 0;
        int   g;
        logic last;
        logic [10:0] e;
        bus.out_ready = (stall_at != 0);
        do_start(MODE_DUMP);
        forever begin
            g = 0;
            while (!bus.out_valid && g < 20) begin
                tick();
                g++;
            end
            if (g >= 20) begin
                check({name, " out_valid timeout"}, 32'd0, 32'd1);
                break;
            end
            if (exp_q.size() == 0) begin
                check({name, " unexpected beat"}, {bus.out_last, bus.out_sym, bus.out_count}, 0);
                break;
            end
            if (b == stall_at) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check({name, " stalled beat"}, {bus.out_last, bus.out_sym, bus.out_count},
                          exp_q[0]);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
            e = exp_q.pop_front();
            check({name, " beat"}, {bus.out_last, bus.out_sym, bus.out_count}, e);
            last = bus.out_last;
            b++;
            tick();
            if (last) break;
        end
        check({name, " beats left"}, exp_q.size(), 0);
        check({name, " busy after last"}, busy, 1'b0);
        bus.out_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic load_alpha(input logic [31:0] a, input int na);
        do_start(MODE_LOAD);
        for (int k = 0; k < na; k++) send_sym(a[8*k +: 8]);
        send_sym(TERM);
    endtask

    task automatic count_text(input logic [47:0] t, input int nt);
        do_start(MODE_COUNT);
        for (int k = 0; k < nt; k++) send_sym(t[8*k +: 8]);
        send_sym(TERM);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        check("outputs zero in reset", outs(), 15'h0);
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{na: 3, alpha: {8'h00, "c", "b", "a"}, nt: 4, text: {16'h0, "a", "c", "b", "a"},
                    cnt: {2'd0, 2'd1, 2'd1, 2'd2}, miss: 2'd0};
        vecs[1] = '{na: 3, alpha: {8'h00, "c", "b", "a"}, nt: 2, text: {32'h0, "z", "x"},
                    cnt: 8'h00, miss: 2'd2};
        vecs[2] = '{na: 0, alpha: 32'h0, nt: 1, text: {40'h0, "a"}, cnt: 8'h00, miss: 2'd1};
        vecs[3] = '{na: 1, alpha: {24'h0, "a"}, nt: 5, text: {8'h0, "a", "a", "a", "a", "a"},
                    cnt: {6'h0, 2'd3}, miss: 2'd0};
        vecs[4] = '{na: 3, alpha: {8'h00, "a", "b", "a"}, nt: 3, text: {24'h0, "b", "b", "a"},
                    cnt: {2'd0, 2'd0, 2'd2, 2'd1}, miss: 2'd0};
        vecs[5] = '{na: 4, alpha: {"d", "c", "b", "a"}, nt: 2, text: {32'h0, "q", "d"},
                    cnt: {2'd1, 2'd0, 2'd0, 2'd0}, miss: 2'd1};

        bus.sym_valid = 1'b0;
        bus.sym_in    = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        check("reset outputs", outs(), 15'h0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            load_alpha(vecs[i].alpha, vecs[i].na);
            count_text(vecs[i].text, vecs[i].nt);
            for (int k = 0; k < vecs[i].na; k++)
                exp_q.push_back(beat(1'b0, vecs[i].alpha[8*k +: 8], vecs[i].cnt[2*k +: 2]));
            exp_q.push_back(beat(1'b1, TERM, vecs[i].miss));
            dump_check($sformatf("vec%0d", i), -1);
        end

        // Search latency, ignored start, backpressure and dump persistence.
        load_alpha({8'h00, "c", "b", "a"}, 3);
        do_start(MODE_COUNT);
        check("count start busy/ready", {busy, bus.sym_ready}, 2'b11);
        do_start(MODE_DUMP);
        check("start ignored in COUNT", {bus.out_valid, bus.sym_ready}, 2'b01);
        send_measure("latency match idx2", "c", 3);
        send_measure("latency match idx0", "a", 1);
        send_measure("latency miss n3", "q", 3);
        send_sym(TERM);
        exp_q.push_back(beat(1'b0, "a", 2'd1));
        exp_q.push_back(beat(1'b0, "b", 2'd0));
        exp_q.push_back(beat(1'b0, "c", 2'd1));
        exp_q.push_back(beat(1'b1, TERM, 2'd1));
        dump_check("stall dump", 1);
`ifdef SYMHIST_CLEAR_ON_READ_EN
        exp_q.push_back(beat(1'b0, "a", 2'd0));
        exp_q.push_back(beat(1'b0, "b", 2'd0));
        exp_q.push_back(beat(1'b0, "c", 2'd0));
        exp_q.push_back(beat(1'b1, TERM, 2'd0));
`else
        exp_q.push_back(beat(1'b0, "a", 2'd1));
        exp_q.push_back(beat(1'b0, "b", 2'd0));
        exp_q.push_back(beat(1'b0, "c", 2'd1));
        exp_q.push_back(beat(1'b1, TERM, 2'd1));
`endif
        dump_check("second dump", 0);

        do_start(2'b11);
        check("reserved mode ignored", {busy, bus.sym_ready}, 2'b00);

        // Table overflow: fifth symbol dropped, flag cleared by the next LOAD start.
        do_start(MODE_LOAD);
        send_sym("a");
        send_sym("b");
        send_sym("c");
        send_sym("d");
        check("no ovf at full", load_ovf, 1'b0);
        send_sym("e");
        send_sym(TERM);
        check("load_ovf set", load_ovf, 1'b1);
        exp_q.push_back(beat(1'b0, "a", 2'd0));
        exp_q.push_back(beat(1'b0, "b", 2'd0));
        exp_q.push_back(beat(1'b0, "c", 2'd0));
        exp_q.push_back(beat(1'b0, "d", 2'd0));
        exp_q.push_back(beat(1'b1, TERM, 2'd0));
        dump_check("ovf dump", -1);
        do_start(MODE_LOAD);
        check("load_ovf cleared", load_ovf, 1'b0);
        send_sym(TERM);

        // Reset during SEARCH.
        load_alpha({"d", "c", "b", "a"}, 4);
        do_start(MODE_COUNT);
        send_sym("d");
        check("in search", {busy, bus.sym_ready}, 2'b10);
        pulse_reset();
        exp_q.push_back(beat(1'b1, TERM, 2'd0));
        dump_check("after search reset", -1);

        // Reset during DUMP.
        load_alpha({16'h0, "b", "a"}, 2);
        count_text({40'h0, "a"}, 1);
        bus.out_ready = 1'b0;
        do_start(MODE_DUMP);
        check("dump beat pre-reset", {bus.out_valid, bus.out_last, bus.out_sym, bus.out_count},
              {1'b1, beat(1'b0, "a", 2'd1)});
        pulse_reset();
        exp_q.push_back(beat(1'b1, TERM, 2'd0));
        dump_check("after dump reset", -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/symbol_histogram.md
# symbol_histogram

Parametrised symbol-occurrence counter, the next generation of the SymbolsCounter block. It loads a programmable alphabet and counts occurrences of each alphabet symbol in a streamed text. It then dumps (symbol, count) pairs, ending with a final beat that carries the count of unmatched symbols. Symbol, count and alphabet widths/depths are parameters; input and output use valid/ready handshakes; counters saturate.

## Interface
- SYM_W, 8, symbol width in bits
- MAX_SYMS, 32, alphabet table depth (≥1)
- CNT_W, 16, per-symbol and miss counter width
- TERM, 0, terminator symbol value (SYM_W bits)

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins the operation selected by mode; honoured only in IDLE
- mode  in  2  00 LOAD, 01 COUNT, 10 DUMP, 11 reserved (start ignored)
- sym_valid  in  1  sym_in valid
- sym_ready  out  1  block accepts sym_in this cycle
- sym_in  in  SYM_W  alphabet or text symbol
- out_valid  out  1  dump beat valid
- out_ready  in  1  downstream accepts beat
- out_sym  out  SYM_W  table symbol; TERM on the final beat
- out_count  out  CNT_W  occurrence count; miss count on the final beat
- out_last  out  1  final dump beat
- busy  out  1  state ≠ IDLE
- load_ovf  out  1  sticky: an alphabet symbol was dropped because the table was full; cleared by the next LOAD start

## Operation
- States: IDLE, LOAD, COUNT, SEARCH, DUMP. Transfer occurs when valid&&ready are both high at a rising edge.
- IDLE, start with mode=LOAD → LOAD:
  - table size n←0, all counts←0, miss←0, load_ovf←0.
- LOAD: sym_ready=1.
  - Accepted TERM → IDLE. TERM is not stored.
  - Other symbol with n<MAX_SYMS: table[n]←sym, n←n+1.
  - Other symbol with n=MAX_SYMS: symbol dropped, load_ovf←1.
  - Duplicate symbols are stored; lookup matches the lowest index.
- IDLE, start with mode=COUNT → COUNT. Counts are not cleared.
- COUNT: sym_ready=1.
  - Accepted TERM → IDLE.
  - Other symbol: latch it, i←0, go to SEARCH.
- SEARCH: sym_ready=0. Compares one entry per cycle.
  - table[i]==sym: count[i]←sat(count[i]+1), → COUNT.
  - No match and i=n-1: miss←sat(miss+1), → COUNT.
  - No match otherwise: i←i+1.
  - n=0: miss increments in the first SEARCH cycle.
- Saturation: a counter at 2^CNT_W-1 holds that value.
- IDLE, start with mode=DUMP → DUMP, j←0.
  - Beats j=0..n-1 carry {table[j], count[j]}.
  - The final beat carries {TERM, miss, out_last=1}.
  - Acceptance of the final beat → IDLE.
  - out_sym, out_count and out_last are held stable while out_valid && !out_ready.
- start outside IDLE is ignored. mode is sampled only on start.
- Counts and table persist across COUNT/DUMP sessions until the next LOAD.

## Timing
- Reset values:
  - All outputs 0: sym_ready, out_valid, out_sym, out_count, out_last, busy, load_ovf.
  - State IDLE, n=0, all counts and miss cleared.
- Reset assertion mid-operation aborts immediately: in-flight symbol and dump are lost, and the table is cleared.
- start at edge k → busy and sym_ready (LOAD/COUNT) high from cycle k+1.
- Symbol matching at index m: the count updates m+1 cycles after acceptance, then sym_ready reasserts the following cycle. Miss path takes n cycles (1 if n=0).
- Throughput in COUNT: one symbol per (match index + 2) cycles.
- DUMP: first out_valid one cycle after start; one beat per cycle when out_ready=1; n+1 beats total.
- After out_last is accepted: busy=0 on the next cycle.

## Configuration
- SYMHIST_CLEAR_ON_READ_EN:
  - Defined: each count (and miss on the final beat) is zeroed in the same edge its dump beat is accepted. Table contents are kept.
  - Undefined: dump is non-destructive.

## Structure
- Package symhist_pkg holds:
  - state enum (IDLE, LOAD, COUNT, SEARCH, DUMP)
  - mode encodings MODE_LOAD=2'b00, MODE_COUNT=2'b01, MODE_DUMP=2'b10
- Sub-module symhist_lookup: sequential search engine. Takes the latched symbol and n, walks the table index, returns hit/index/miss-done.
- Top level holds the FSM, table, counters and dump logic.

## Test plan
- Load {a,b,c,TERM}; count "abca",TERM; dump → beats (a,2),(b,1),(c,1),(TERM,0,last); n=3.
- Same alphabet, count "xz",TERM → all counts 0, final beat miss=2; n=0 load then count "a" → miss=1 after one SEARCH cycle.
- MAX_SYMS=4; load 5 symbols → load_ovf=1, fifth dropped; a new LOAD start clears load_ovf.
- CNT_W=2; count 'a' five times → dump gives (a,3) (saturated).
- Dump with out_ready low for 3 cycles mid-stream → beat held stable, no beat lost or duplicated; with SYMHIST_CLEAR_ON_READ_EN, a second dump returns all zeros.
- reset_n asserted during SEARCH and during DUMP → all outputs 0 immediately, busy=0; a subsequent dump returns only (TERM,0,last).
